decode_stage: RTL and testbench

Parametrised, handshaked successor to the single-cycle instruction decoder: sits between fetch and execute and consumes a stream of instruction words under valid/ready. Two-word (long-form, opcode bit 7 set) instructions are assembled into one decoded bundle with the second word captured as the immediate. Supports back-pressure from execute, flush on branch redirect, and a legacy single-word mode.

---
 rtl/decode_stage_pkg.sv | 49 ++++
 rtl/decode_stage_fields.sv | 65 ++++++
 rtl/decode_stage.sv | 153 +++++++++++++++
 tb/tb_decode_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared CPU constants for the decode stage.
//   - OPC_* : 8-bit opcode encodings (bit 7 of an encoded opcode marks the
//             long-form variant; constants below are the short-form bases).
//   - state_e : decode FSM states (S_OP = expect opcode, S_IMM = expect imm).
//   - ctrl_t  : width-independent control fields of a decoded bundle.
package decode_stage_pkg;

  localparam logic [7:0] OPC_NOP     = 8'h00;
  localparam logic [7:0] OPC_ADD     = 8'h01;
  localparam logic [7:0] OPC_SUB     = 8'h02;
  localparam logic [7:0] OPC_AND     = 8'h03;
  localparam logic [7:0] OPC_OR      = 8'h04;
  localparam logic [7:0] OPC_XOR     = 8'h05;
  localparam logic [7:0] OPC_MOV     = 8'h06;
  localparam logic [7:0] OPC_CMP     = 8'h07;
  localparam logic [7:0] OPC_ST      = 8'h10;
  localparam logic [7:0] OPC_LD      = 8'h11;
  localparam logic [7:0] OPC_LDI     = 8'h12;
  localparam logic [7:0] OPC_STI     = 8'h13;
  localparam logic [7:0] OPC_PUSH    = 8'h14;
  localparam logic [7:0] OPC_POP     = 8'h15;
  localparam logic [7:0] OPC_PUSHI   = 8'h16;
  localparam logic [7:0] OPC_PUSHLR  = 8'h17;
  localparam logic [7:0] OPC_SPEC    = 8'h18;
  localparam logic [7:0] OPC_JMP     = 8'h20;
  localparam logic [7:0] OPC_JMPI    = 8'h21;
  localparam logic [7:0] OPC_SET     = 8'h22;
  localparam logic [7:0] OPC_CALL    = 8'h23;
  localparam logic [7:0] OPC_CALLI   = 8'h24;
  // MOVB_Rn occupy eight consecutive codes; rD is the offset from R0.
  localparam logic [7:0] OPC_MOVB_R0 = 8'h40;
  localparam logic [7:0] OPC_MOVB_R7 = 8'h47;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0] alu;
    logic       en_immediate;
    logic       en_mem;
    logic       mem_byte;
    logic       mem_displacement;
    logic       lr_is_input;
    logic [3:0] condition;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_fields.sv
// decode_stage_fields: pure combinational decode of one 16-bit opcode word.
// Ports:
//   word_i     in  16         opcode word (opcode in [15:8])
//   ctrl_o     out ctrl_t     ALU / memory / condition controls
//   rd_o, rs_o out REG_SEL_W  register selects (zero-extended fields)
//   imm_byte_o out 8          MOVB immediate byte (0 for other opcodes)
//   is_long_o  out 1          long-form opcode (bit 7 set, not MOVB)
module decode_stage_fields
  import decode_stage_pkg::*;
#(
  parameter int REG_SEL_W = 3,
  parameter int SP_REG    = 7
) (
  input  logic [15:0]          word_i,
  output ctrl_t                ctrl_o,
  output logic [REG_SEL_W-1:0] rd_o,
  output logic [REG_SEL_W-1:0] rs_o,
  output logic [7:0]           imm_byte_o,
  output logic                 is_long_o
);

  logic [7:0] opcode;
  logic [7:0] base;

  assign opcode = word_i[15:8];
  // Field selection keys off the short-form base so long variants decode alike.
  assign base   = {1'b0, opcode[6:0]};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    ctrl_o     = '0;
    rd_o       = '0;
    rs_o       = '0;
    imm_byte_o = '0;
    is_long_o  = 1'b0;

    if (opcode >= OPC_MOVB_R0 && opcode <= OPC_MOVB_R7) begin
      ctrl_o.alu          = OPC_MOV;
      ctrl_o.en_immediate = 1'b1;
      rd_o                = REG_SEL_W'(opcode - OPC_MOVB_R0);
      imm_byte_o          = word_i[7:0];
    end else begin
      ctrl_o.alu          = base;
      ctrl_o.en_immediate = opcode[7];
      is_long_o           = opcode[7];
      rd_o                = REG_SEL_W'(word_i[2:0]);
      if (base inside {OPC_PUSH, OPC_POP, OPC_PUSHI, OPC_PUSHLR})
        rs_o = REG_SEL_W'(SP_REG);
      else
        rs_o = REG_SEL_W'(word_i[5:3]);

      ctrl_o.en_mem = base inside {OPC_ST, OPC_LD, OPC_LDI, OPC_STI,
                                   OPC_PUSH, OPC_PUSHI, OPC_POP, OPC_PUSHLR};
      if (base inside {OPC_ST, OPC_LD, OPC_LDI, OPC_STI})
        ctrl_o.mem_byte = word_i[7];
      if (base inside {OPC_LDI, OPC_STI})
        ctrl_o.mem_displacement = word_i[6];
      ctrl_o.lr_is_input = base inside {OPC_SPEC, OPC_PUSHLR};
      if (base inside {OPC_JMP, OPC_JMPI, OPC_SET, OPC_CALL, OPC_CALLI})
        ctrl_o.condition = word_i[6:3];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: handshaked instruction decoder between fetch and execute.
// Assembles long-form (opcode bit 7) instructions from two words when
// EN_LONG=1; otherwise decodes single words and flags next_word.
// DATA_W must be >= 16; only in_word[15:0] is decoded as an opcode.
// Ports:
//   clk, rst (async, active-high), flush_i (drops partial + pending bundle)
//   in_valid_i / in_ready_o / in_word_i      : fetch-side handshake
//   out_valid_o / out_ready_i                : execute-side handshake
//   alu_control_o, rD_sel_o, rS_sel_o, immediate_o, en_immediate_o,
//   next_word_o, long_insn_o, en_mem_o, mem_byte_o, mem_displacement_o,
//   lr_is_input_o, condition_o               : registered decoded bundle
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 3,
  parameter int SP_REG    = 7,
  parameter bit EN_LONG   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATA_W-1:0]    in_word_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [7:0]           alu_control_o,
  output logic [REG_SEL_W-1:0] rD_sel_o,
  output logic [REG_SEL_W-1:0] rS_sel_o,
  output logic [DATA_W-1:0]    immediate_o,
  output logic                 en_immediate_o,
  output logic                 next_word_o,
  output logic                 long_insn_o,
  output logic                 en_mem_o,
  output logic                 mem_byte_o,
  output logic                 mem_displacement_o,
  output logic                 lr_is_input_o,
  output logic [3:0]           condition_o
);

  typedef struct packed {
    ctrl_t                ctrl;
    logic [REG_SEL_W-1:0] rd;
    logic [REG_SEL_W-1:0] rs;
    logic [DATA_W-1:0]    imm;
    logic                 next_word;
    logic                 long_insn;
  } bundle_t;

  state_e  state_q, state_d;
  bundle_t pend_q, pend_d;
  bundle_t out_q, out_d;
  logic    out_valid_q, out_valid_d;

  ctrl_t                dec_ctrl;
  logic [REG_SEL_W-1:0] dec_rd, dec_rs;
  logic [7:0]           dec_imm_byte;
  logic                 dec_is_long;
  bundle_t              dec_bundle;
  logic                 accept;

  decode_stage_fields #(
    .REG_SEL_W (REG_SEL_W),
    .SP_REG    (SP_REG)
  ) u_fields (
    .word_i     (in_word_i[15:0]),
    .ctrl_o     (dec_ctrl),
    .rd_o       (dec_rd),
    .rs_o       (dec_rs),
    .imm_byte_o (dec_imm_byte),
    .is_long_o  (dec_is_long)
  );

  // Single-word bundle straight from the decoder; in legacy mode a long-form
  // opcode still completes here, with immediate 0 and next_word raised.
  always_comb begin
    dec_bundle           = '0;
    dec_bundle.ctrl      = dec_ctrl;
    dec_bundle.rd        = dec_rd;
    dec_bundle.rs        = dec_rs;
    dec_bundle.imm       = DATA_W'(dec_imm_byte);
    dec_bundle.next_word = dec_is_long & ~EN_LONG;
  end

  // Held off during reset, on flush, and while a bundle waits for execute.
  assign in_ready_o = ~rst & ~flush_i & (~out_valid_q | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    out_d       = out_q;
    out_valid_d = out_valid_q & ~out_ready_i;

    if (flush_i) begin
      state_d     = S_OP;
      out_valid_d = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        S_OP: begin
          if (dec_is_long && EN_LONG) begin
            pend_d  = dec_bundle;
            state_d = S_IMM;
          end else begin
            out_d       = dec_bundle;
            out_valid_d = 1'b1;
          end
        end
        S_IMM: begin
          out_d           = pend_q;
          out_d.imm       = in_word_i;
          out_d.long_insn = 1'b1;
          out_d.next_word = 1'b0;
          out_valid_d     = 1'b1;
          state_d         = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OP;
      pend_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      pend_q      <= pend_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o        = out_valid_q;
  assign alu_control_o      = out_q.ctrl.alu;
  assign rD_sel_o           = out_q.rd;
  assign rS_sel_o           = out_q.rs;
  assign immediate_o        = out_q.imm;
  assign en_immediate_o     = out_q.ctrl.en_immediate;
  assign next_word_o        = out_q.next_word;
  assign long_insn_o        = out_q.long_insn;
  assign en_mem_o           = out_q.ctrl.en_mem;
  assign mem_byte_o         = out_q.ctrl.mem_byte;
  assign mem_displacement_o = out_q.ctrl.mem_displacement;
  assign lr_is_input_o      = out_q.ctrl.lr_is_input;
  assign condition_o        = out_q.ctrl.condition;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors for decode_stage, with a second instance
// built in legacy single-word mode (EN_LONG=0).
module tb_decode_stage;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid, in_valid_l;
  logic [DATA_W-1:0] in_word;
  logic              out_ready;

  // Main instance outputs
  logic                 in_ready, out_valid;
  logic [7:0]           alu;
  logic [REG_SEL_W-1:0] rd, rs;
  logic [DATA_W-1:0]    imm;
  logic                 en_imm, next_word, long_insn, en_mem, mem_byte, mem_disp, lr_in;
  logic [3:0]           cond;

  // Legacy instance outputs
  logic                 in_ready_l, out_valid_l;
  logic [7:0]           alu_l;
  logic [REG_SEL_W-1:0] rd_l, rs_l;
  logic [DATA_W-1:0]    imm_l;
  logic                 en_imm_l, next_word_l, long_insn_l, en_mem_l, mem_byte_l, mem_disp_l, lr_in_l;
  logic [3:0]           cond_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .SP_REG(7), .EN_LONG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_word_i(in_word),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_control_o(alu), .rD_sel_o(rd), .rS_sel_o(rs), .immediate_o(imm),
    .en_immediate_o(en_imm), .next_word_o(next_word), .long_insn_o(long_insn),
    .en_mem_o(en_mem), .mem_byte_o(mem_byte), .mem_displacement_o(mem_disp),
    .lr_is_input_o(lr_in), .condition_o(cond)
  );

  decode_stage #(.DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .SP_REG(7), .EN_LONG(1'b0)) u_dut_legacy (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid_l), .in_ready_o(in_ready_l), .in_word_i(in_word),
    .out_valid_o(out_valid_l), .out_ready_i(out_ready),
    .alu_control_o(alu_l), .rD_sel_o(rd_l), .rS_sel_o(rs_l), .immediate_o(imm_l),
    .en_immediate_o(en_imm_l), .next_word_o(next_word_l), .long_insn_o(long_insn_l),
    .en_mem_o(en_mem_l), .mem_byte_o(mem_byte_l), .mem_displacement_o(mem_disp_l),
    .lr_is_input_o(lr_in_l), .condition_o(cond_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_valid_l = 1'b0;
    in_word    = '0;
    out_ready  = 1'b1;

    // ---- reset state ----
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu", 32'(alu), 32'd0);
    check("rst_imm", 32'(imm), 32'd0);
    check("rst_en_imm", 32'(en_imm), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // ---- MOVB R3, 0xA5 ----
    in_valid = 1'b1;
    in_word  = 16'h43A5;
    step();
    in_valid = 1'b0;
    check("movb_valid", 32'(out_valid), 32'd1);
    check("movb_alu", 32'(alu), 32'h06);
    check("movb_rd", 32'(rd), 32'd3);
    check("movb_imm", 32'(imm), 32'h00A5);
    check("movb_en_imm", 32'(en_imm), 32'd1);
    check("movb_long", 32'(long_insn), 32'd0);
    step();
    check("movb_consumed", 32'(out_valid), 32'd0);

    // ---- long-form ADD r2, #0x1234 ----
    in_valid = 1'b1;
    in_word  = 16'h8102;
    step();
    check("long_first_no_bundle", 32'(out_valid), 32'd0);
    in_word = 16'h1234;
    step();
    in_valid = 1'b0;
    check("long_valid", 32'(out_valid), 32'd1);
    check("long_alu", 32'(alu), 32'h01);
    check("long_rd", 32'(rd), 32'd2);
    check("long_imm", 32'(imm), 32'h1234);
    check("long_insn", 32'(long_insn), 32'd1);
    check("long_en_imm", 32'(en_imm), 32'd1);
    check("long_next_word", 32'(next_word), 32'd0);
    step();
    check("long_single_bundle", 32'(out_valid), 32'd0);

    // ---- PUSH (rS forced to SP) then LDI with byte+displacement ----
    in_valid = 1'b1;
    in_word  = 16'h1408;
    step();
    check("push_alu", 32'(alu), 32'h14);
    check("push_rs_sp", 32'(rs), 32'd7);
    check("push_en_mem", 32'(en_mem), 32'd1);
    check("push_mem_byte", 32'(mem_byte), 32'd0);
    in_word = 16'h12C0;
    step();
    in_valid = 1'b0;
    check("ldi_alu", 32'(alu), 32'h12);
    check("ldi_mem_byte", 32'(mem_byte), 32'd1);
    check("ldi_mem_disp", 32'(mem_disp), 32'd1);
    check("ldi_en_mem", 32'(en_mem), 32'd1);
    check("ldi_rs", 32'(rs), 32'd0);
    step();

    // ---- back-to-back ADD r1, SUB r2, XOR r3 with stall on SUB ----
    in_valid = 1'b1;
    in_word  = 16'h0101;
    step();
    check("b2b_a_alu", 32'(alu), 32'h01);
    check("b2b_a_rd", 32'(rd), 32'd1);
    in_word = 16'h0202;
    step();
    check("b2b_b_alu", 32'(alu), 32'h02);
    out_ready = 1'b0;
    in_word   = 16'h0503;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    step();
    check("stall1_valid", 32'(out_valid), 32'd1);
    check("stall1_alu", 32'(alu), 32'h02);
    check("stall1_rd", 32'(rd), 32'd2);
    step();
    check("stall2_alu", 32'(alu), 32'h02);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b_c_valid", 32'(out_valid), 32'd1);
    check("b2b_c_alu", 32'(alu), 32'h05);
    check("b2b_c_rd", 32'(rd), 32'd3);
    step();
    check("b2b_no_dup", 32'(out_valid), 32'd0);

    // ---- flush during S_IMM ----
    in_valid = 1'b1;
    in_word  = 16'h8103;
    step();
    flush   = 1'b1;
    in_word = 16'h9999;
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    check("flush_no_bundle", 32'(out_valid), 32'd0);
    in_word = 16'h4577;
    step();
    in_valid = 1'b0;
    check("after_flush_valid", 32'(out_valid), 32'd1);
    check("after_flush_alu", 32'(alu), 32'h06);
    check("after_flush_rd", 32'(rd), 32'd5);
    check("after_flush_imm", 32'(imm), 32'h0077);
    check("after_flush_long", 32'(long_insn), 32'd0);

    // ---- flush drops a stalled pending bundle ----
    out_ready = 1'b0;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b1;
    check("flush_drops_pending", 32'(out_valid), 32'd0);

    // ---- reset in the middle of a long-form instruction ----
    in_valid = 1'b1;
    in_word  = 16'h8101;
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("midrst_no_bundle", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_word  = 16'h1234;
    step();
    in_valid = 1'b0;
    check("midrst_opcode_valid", 32'(out_valid), 32'd1);
    check("midrst_opcode_alu", 32'(alu), 32'h12);
    check("midrst_opcode_long", 32'(long_insn), 32'd0);
    step();

    // ---- legacy mode: long-form JMP, condition 0b1010 ----
    in_valid_l = 1'b1;
    in_word    = 16'hA050;
    step();
    in_valid_l = 1'b0;
    check("legacy_valid", 32'(out_valid_l), 32'd1);
    check("legacy_alu", 32'(alu_l), 32'h20);
    check("legacy_next_word", 32'(next_word_l), 32'd1);
    check("legacy_imm", 32'(imm_l), 32'd0);
    check("legacy_cond", 32'(cond_l), 32'hA);
    check("legacy_long", 32'(long_insn_l), 32'd0);
    check("legacy_en_imm", 32'(en_imm_l), 32'd1);
    check("legacy_main_idle", 32'(out_valid), 32'd0);
    step();
    check("legacy_single_bundle", 32'(out_valid_l), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
